// File: rtl/bram_pkg.sv
// Shared defaults and types for the BRAM write-back path.
package bram_pkg;

  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned DEF_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  typedef logic [DEF_DATA_W-1:0] row_t;

endpackage

// File: rtl/wb_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags.
module wb_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              do_push;
  logic              do_pop;

  // Qualify requests; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointers, occupancy and flags; flags are derived from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents need no reset since the flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/bram_writeback.sv
// Streams one frame of ROWS result rows into a BRAM write port.
module bram_writeback
  import bram_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              wr_grant,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(ROWS + 1);

  wb_state_t         state;
  wb_state_t         state_nxt;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] addr_ptr;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  logic              push;
  logic              pop;
  logic              last_pop;

  logic              en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              busy_d;
  logic              done_d;

  wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_W    (DATA_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (s_data),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Handshake decode; ready depends only on registered state, never on wr_grant.
  always_comb begin
    s_ready  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    last_pop = 1'b0;
    if (state == WRITE) begin
      s_ready  = !fifo_full && (acc_cnt < CNT_W'(ROWS));
      push     = s_valid && s_ready;
      pop      = !fifo_empty && wr_grant;
      last_pop = pop && (wr_cnt == CNT_W'(ROWS - 1));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (last_pop) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered BRAM port and status outputs.
  always_comb begin
    en_d   = pop;
    addr_d = bram_addr;
    din_d  = bram_din;
    busy_d = (state_nxt != IDLE);
    done_d = (state_nxt == DONE);
    if (pop) begin
      addr_d = addr_ptr;
      din_d  = fifo_dout;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      bram_en   <= en_d;
      bram_we   <= en_d;
      bram_addr <= addr_d;
      bram_din  <= din_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Frame counters; addr_ptr tracks (base + wr_cnt) and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      addr_ptr <= '0;
    end else if ((state == IDLE) && start) begin
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      addr_ptr <= base_addr;
    end else begin
      if (push) acc_cnt <= acc_cnt + CNT_W'(1);
      if (pop) begin
        wr_cnt   <= wr_cnt + CNT_W'(1);
        addr_ptr <= addr_ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bram_writeback.sv
// Directed and randomized checks for bram_writeback.
module tb_bram_writeback;
  import bram_pkg::*;

  localparam int unsigned DATA_W     = DEF_DATA_W;
  localparam int unsigned ADDR_W     = DEF_ADDR_W;
  localparam int unsigned ROWS       = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CW         = DATA_W + 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              wr_grant;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              done;

  int total  = 0;
  int passed = 0;

  bram_writeback #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ROWS      (ROWS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .wr_grant (wr_grant),
    .bram_en  (bram_en),
    .bram_we  (bram_we),
    .bram_addr(bram_addr),
    .bram_din (bram_din),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write monitor: records every BRAM write with its cycle stamp.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    row_t              data;
    int                cyc;
  } wr_t;

  wr_t wq[$];
  int  cyc_cnt  = 0;
  int  done_cnt = 0;

  always @(posedge clk) begin
    #1;
    cyc_cnt++;
    if (bram_we) wq.push_back('{bram_addr, bram_din, cyc_cnt});
    if (done) begin
      done_cnt++;
      check("done_with_last_write", CW'(bram_we), CW'(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Cycle vectors: inputs applied before an edge, expected outputs after it.
  typedef struct packed {
    logic              st;
    logic [ADDR_W-1:0] b;
    logic              sv;
    logic [7:0]        sd;
    logic              gr;
    logic              rdy;
    logic              en;
    logic [ADDR_W-1:0] a;
    logic [7:0]        dn;
    logic              by;
    logic              dd;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [ADDR_W-1:0] b, input logic sv,
                              input logic [7:0] sd, input logic gr, input logic rdy,
                              input logic en, input logic [ADDR_W-1:0] a, input logic [7:0] dn,
                              input logic by, input logic dd);
    mk = '{st, b, sv, sd, gr, rdy, en, a, dn, by, dd};
  endfunction

  task automatic run_frame(input logic [ADDR_W-1:0] base, input logic [7:0] dbase,
                           input int beats, input bit rnd, input int stall_after,
                           input int stall_len, input bit restart_mid, input string tag);
    int sent = 0;
    int cyc = 0;
    int w0;
    int d0;
    int n;
    int stall_left;
    int stall_ws = -1;
    bit last_stall = 1'b0;
    bit hs;
    logic [7:0] d;
    w0 = wq.size();
    d0 = done_cnt;
    stall_left = stall_len;
    start = 1'b1; base_addr = base; s_valid = 1'b0; wr_grant = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_ready"}, CW'({busy, s_ready}), CW'(2'b11));
    while (done_cnt == d0 && cyc < 500) begin
      s_valid = (sent < beats) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      d = dbase + 8'(sent);
      s_data = DATA_W'(d);
      if (rnd) begin
        wr_grant = ($urandom_range(0, 1) == 1);
      end else if (stall_left > 0 && (wq.size() - w0) >= stall_after) begin
        if (stall_left == stall_len) stall_ws = wq.size() - w0;
        wr_grant = 1'b0;
        stall_left--;
        if (stall_left == 0) last_stall = 1'b1;
      end else begin
        wr_grant = 1'b1;
      end
      start     = restart_mid && (cyc == 2);
      base_addr = (restart_mid && cyc == 2) ? ~base : base;
      hs = s_valid && s_ready;
      tick();
      if (hs) sent++;
      cyc++;
      if (last_stall) begin
        last_stall = 1'b0;
        check({tag, "_stall_no_we"}, CW'(wq.size() - w0), CW'(stall_ws));
        check({tag, "_stall_ready_low"}, CW'(s_ready), CW'(0));
        check({tag, "_stall_accepted"}, CW'(sent), CW'(ROWS));
      end
    end
    start = 1'b0; s_valid = 1'b0; wr_grant = 1'b1; base_addr = base;
    check({tag, "_done_seen"}, CW'(done_cnt - d0), CW'(1));
    tick();
    check({tag, "_idle"}, CW'({busy, done, bram_we, s_ready}), CW'(0));
    check({tag, "_done_once"}, CW'(done_cnt - d0), CW'(1));
    check({tag, "_accepted"}, CW'(sent), CW'(ROWS));
    n = wq.size() - w0;
    check({tag, "_nwrites"}, CW'(n), CW'(ROWS));
    for (int k = 0; k < n && k < int'(ROWS); k++)
      check({tag, "_wr"}, CW'({wq[w0+k].addr, wq[w0+k].data}),
            CW'({ADDR_W'(base + k), DATA_W'(dbase + 8'(k))}));
    if (stall_len > 0) begin
      check({tag, "_stall_start_writes"}, CW'(stall_ws), CW'(stall_after));
      if (n >= int'(ROWS))
        check({tag, "_back_to_back"}, CW'(wq[w0+ROWS-1].cyc - wq[w0+1].cyc), CW'(ROWS - 2));
    end
  endtask

  vec_t tbl[$];

  initial begin
    int w0;
    int sent;
    int cyc;
    bit hs;

    rst = 1'b1; start = 1'b0; base_addr = '0; s_valid = 1'b0; s_data = '0; wr_grant = 1'b0;
    repeat (2) tick();
    check("reset_state", CW'({s_ready, bram_en, bram_we, bram_addr, bram_din, busy, done}), CW'(0));
    rst = 1'b0;
    tick();

    // Basic frame at base 0, then wrap frame at base 3, then a start during DONE.
    tbl.push_back(mk(1, 0, 1, 8'hA0, 1, 1, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hA0, 1, 1, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hA1, 1, 1, 1, 0, 8'hA0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hA2, 1, 1, 1, 1, 8'hA1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hA3, 1, 0, 1, 2, 8'hA2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 1, 3, 8'hA3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 3, 8'hA3, 0, 0));
    tbl.push_back(mk(1, 3, 1, 8'hB0, 1, 1, 0, 3, 8'hA3, 1, 0));
    tbl.push_back(mk(0, 3, 1, 8'hB0, 1, 1, 0, 3, 8'hA3, 1, 0));
    tbl.push_back(mk(0, 3, 1, 8'hB1, 1, 1, 1, 3, 8'hB0, 1, 0));
    tbl.push_back(mk(0, 3, 1, 8'hB2, 1, 1, 1, 0, 8'hB1, 1, 0));
    tbl.push_back(mk(0, 3, 1, 8'hB3, 1, 0, 1, 1, 8'hB2, 1, 0));
    tbl.push_back(mk(0, 3, 0, 8'h00, 1, 0, 1, 2, 8'hB3, 1, 1));
    tbl.push_back(mk(1, 1, 1, 8'hEE, 1, 0, 0, 2, 8'hB3, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'hEE, 1, 0, 0, 2, 8'hB3, 0, 0));

    foreach (tbl[i]) begin
      start = tbl[i].st; base_addr = tbl[i].b; s_valid = tbl[i].sv;
      s_data = DATA_W'(tbl[i].sd); wr_grant = tbl[i].gr;
      tick();
      check($sformatf("vec%0d", i),
            CW'({s_ready, bram_en, bram_we, bram_addr, bram_din, busy, done}),
            CW'({tbl[i].rdy, tbl[i].en, tbl[i].en, tbl[i].a, DATA_W'(tbl[i].dn), tbl[i].by, tbl[i].dd}));
    end
    start = 1'b0; s_valid = 1'b0;
    tick();

    run_frame(2'd0, 8'hC0, 4, 1'b0, 1, 10, 1'b0, "stall");
    run_frame(2'd0, 8'h50, 6, 1'b0, 0, 0, 1'b1, "overrun");

    // Reset in the middle of a frame after two writes.
    start = 1'b1; base_addr = 2'd0; tick();
    start = 1'b0;
    w0 = wq.size(); sent = 0; cyc = 0;
    while ((wq.size() - w0) < 2 && cyc < 50) begin
      s_valid = 1'b1; s_data = DATA_W'(8'hD0 + 8'(sent)); wr_grant = 1'b1;
      hs = s_valid && s_ready;
      tick();
      if (hs) sent++;
      cyc++;
    end
    check("rst_mid_two_writes", CW'(wq.size() - w0), CW'(2));
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", CW'({s_ready, bram_en, bram_we, bram_addr, bram_din, busy, done}), CW'(0));
    rst = 1'b0;
    w0 = wq.size();
    repeat (6) tick();
    check("rst_mid_no_writes", CW'(wq.size() - w0), CW'(0));
    check("rst_mid_idle", CW'({busy, s_ready}), CW'(0));
    s_valid = 1'b0;
    run_frame(2'd1, 8'hE0, 4, 1'b0, 0, 0, 1'b0, "after_rst");

    for (int f = 0; f < 50; f++)
      run_frame(ADDR_W'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 4, 1'b1, 0, 0, 1'b0,
                $sformatf("rnd%0d", f));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
